// File: rtl/id_ex_decode_if.sv
// Decode-to-execute handshake bundle: decode-side request, register operands,
// and the registered ALU-stage entry returned by the decoder.
interface id_ex_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_opnd1;
  logic [31:0] alu_opnd2;
  logic [4:0]  wr_reg;
  logic        wr_en;
  logic        illegal;
  logic [15:0] issue_cnt;

  modport master (
    output in_valid, instr, rs_data, rt_data, flush, out_ready,
    input  in_ready, out_valid, alu_op, alu_opnd1, alu_opnd2,
           wr_reg, wr_en, illegal, issue_cnt
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, flush, out_ready,
    output in_ready, out_valid, alu_op, alu_opnd1, alu_opnd2,
           wr_reg, wr_en, illegal, issue_cnt
  );
endinterface

// File: rtl/id_ex_decode.sv
// ID/EX pipeline register with MIPS ALU-subset decode: one registered entry,
// valid/ready handshake, flush, illegal-instruction flag and issue counter.
module id_ex_decode (
  input  logic           clk,
  input  logic           rst_n,
  id_ex_decode_if.slave  bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_AND  = 4'b0001,
    ALU_NOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_MOV  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_SUB  = 4'b1010,
    ALU_XOR  = 4'b1011,
    ALU_CMP0 = 4'b1100
  } alu_op_e;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  alu_op_e     dec_op;
  logic [31:0] dec_opnd1;
  logic [31:0] dec_opnd2;
  logic [4:0]  dec_wr_reg;
  logic        dec_illegal;

  logic        capture;

  logic        out_valid_q, out_valid_d;
  logic [3:0]  alu_op_q,    alu_op_d;
  logic [31:0] alu_opnd1_q, alu_opnd1_d;
  logic [31:0] alu_opnd2_q, alu_opnd2_d;
  logic [4:0]  wr_reg_q,    wr_reg_d;
  logic        wr_en_q,     wr_en_d;
  logic        illegal_q,   illegal_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;

  // The rs index is already resolved into rs_data by the register file.
  logic unused_rs_idx;
  assign unused_rs_idx = ^bus.instr[25:21];

  assign opcode   = bus.instr[31:26];
  assign funct    = bus.instr[5:0];
  assign imm_sext = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign imm_zext = {16'b0, bus.instr[15:0]};

  always_comb begin
    dec_op      = ALU_ADD;
    dec_opnd1   = '0;
    dec_opnd2   = '0;
    dec_wr_reg  = '0;
    dec_illegal = 1'b0;

    case (opcode)
      6'b000000: begin
        dec_opnd1  = bus.rs_data;
        dec_opnd2  = bus.rt_data;
        dec_wr_reg = bus.instr[15:11];
        case (funct)
          6'b100000, 6'b100001: dec_op = ALU_ADD;
          6'b100010, 6'b100011: dec_op = ALU_SUB;
          6'b100100:            dec_op = ALU_AND;
          6'b100101:            dec_op = ALU_OR;
          6'b100110:            dec_op = ALU_XOR;
          6'b100111:            dec_op = ALU_NOR;
          6'b101010:            dec_op = ALU_SLT;
          6'b101011:            dec_op = ALU_SLTU;
          6'b001010:            dec_op = ALU_MOV;
          // Constant shifts carry shamt in opnd1 instead of rs.
          6'b000000: begin
            dec_op    = ALU_SLL;
            dec_opnd1 = {27'b0, bus.instr[10:6]};
          end
          6'b000010: begin
            dec_op    = ALU_SRL;
            dec_opnd1 = {27'b0, bus.instr[10:6]};
          end
          6'b000011: begin
            dec_op    = ALU_SRA;
            dec_opnd1 = {27'b0, bus.instr[10:6]};
          end
          6'b000100:            dec_op = ALU_SLL;
          6'b000110:            dec_op = ALU_SRL;
          6'b000111:            dec_op = ALU_SRA;
          default:              dec_illegal = 1'b1;
        endcase
      end
      6'b001000, 6'b001001, 6'b001010: begin
        dec_op     = (opcode == 6'b001010) ? ALU_SLT : ALU_ADD;
        dec_opnd1  = bus.rs_data;
        dec_opnd2  = imm_sext;
        dec_wr_reg = bus.instr[20:16];
      end
      6'b001100, 6'b001101, 6'b001110: begin
        dec_op     = (opcode == 6'b001100) ? ALU_AND :
                     (opcode == 6'b001101) ? ALU_OR  : ALU_XOR;
        dec_opnd1  = bus.rs_data;
        dec_opnd2  = imm_zext;
        dec_wr_reg = bus.instr[20:16];
      end
      6'b001111: begin
        dec_op     = ALU_SLL;
        dec_opnd1  = 32'd16;
        dec_opnd2  = imm_zext;
        dec_wr_reg = bus.instr[20:16];
      end
      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_op     = ALU_ADD;
      dec_opnd1  = '0;
      dec_opnd2  = '0;
      dec_wr_reg = '0;
    end
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    alu_opnd1_d = alu_opnd1_q;
    alu_opnd2_d = alu_opnd2_q;
    wr_reg_d    = wr_reg_q;
    wr_en_d     = wr_en_q;
    illegal_d   = illegal_q;
    issue_cnt_d = issue_cnt_q;

    // Flush wins over capture and consume alike.
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      alu_op_d    = dec_op;
      alu_opnd1_d = dec_opnd1;
      alu_opnd2_d = dec_opnd2;
      wr_reg_d    = dec_wr_reg;
      wr_en_d     = !dec_illegal && (dec_wr_reg != 5'd0);
      illegal_d   = dec_illegal;
      if (!dec_illegal) begin
        issue_cnt_d = issue_cnt_q + 16'd1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= 4'b0000;
      alu_opnd1_q <= '0;
      alu_opnd2_q <= '0;
      wr_reg_q    <= '0;
      wr_en_q     <= 1'b0;
      illegal_q   <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      alu_opnd1_q <= alu_opnd1_d;
      alu_opnd2_q <= alu_opnd2_d;
      wr_reg_q    <= wr_reg_d;
      wr_en_q     <= wr_en_d;
      illegal_q   <= illegal_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_opnd1 = alu_opnd1_q;
  assign bus.alu_opnd2 = alu_opnd2_q;
  assign bus.wr_reg    = wr_reg_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.illegal   = illegal_q;
  assign bus.issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_id_ex_decode.sv
// Bench for id_ex_decode: directed scenarios plus randomized traffic checked
// against a mnemonic-level decode model and an ideal one-entry pipeline register.
module tb_id_ex_decode;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_decode_if bus ();

  id_ex_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [4:0]  wr;
    logic        we;
    logic        ill;
  } dec_t;

  logic        m_valid;
  dec_t        m_ent;
  logic [15:0] m_cnt;

  // Decode straight from the ISA tables: classify the word, then fill fields.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    dec_t        d;
    logic [5:0]  opc = ins[31:26];
    logic [5:0]  fn  = ins[5:0];
    logic [31:0] sx  = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] zx  = {16'h0000, ins[15:0]};
    logic [31:0] sh  = {27'b0, ins[10:6]};
    d = '0;
    d.ill = 1'b1;
    if (opc == 6'h00) begin
      d = '{op: 4'd0, o1: rs, o2: rt, wr: ins[15:11], we: 1'b0, ill: 1'b0};
      case (fn)
        6'h20, 6'h21: d.op = 4'd0;
        6'h22, 6'h23: d.op = 4'd10;
        6'h24:        d.op = 4'd1;
        6'h25:        d.op = 4'd3;
        6'h26:        d.op = 4'd11;
        6'h27:        d.op = 4'd2;
        6'h2A:        d.op = 4'd8;
        6'h2B:        d.op = 4'd9;
        6'h0A:        d.op = 4'd4;
        6'h00:        begin d.op = 4'd5; d.o1 = sh; end
        6'h02:        begin d.op = 4'd6; d.o1 = sh; end
        6'h03:        begin d.op = 4'd7; d.o1 = sh; end
        6'h04:        d.op = 4'd5;
        6'h06:        d.op = 4'd6;
        6'h07:        d.op = 4'd7;
        default:      d.ill = 1'b1;
      endcase
    end else begin
      case (opc)
        6'h08, 6'h09: d = '{op: 4'd0,  o1: rs,    o2: sx, wr: ins[20:16], we: 1'b0, ill: 1'b0};
        6'h0A:        d = '{op: 4'd8,  o1: rs,    o2: sx, wr: ins[20:16], we: 1'b0, ill: 1'b0};
        6'h0C:        d = '{op: 4'd1,  o1: rs,    o2: zx, wr: ins[20:16], we: 1'b0, ill: 1'b0};
        6'h0D:        d = '{op: 4'd3,  o1: rs,    o2: zx, wr: ins[20:16], we: 1'b0, ill: 1'b0};
        6'h0E:        d = '{op: 4'd11, o1: rs,    o2: zx, wr: ins[20:16], we: 1'b0, ill: 1'b0};
        6'h0F:        d = '{op: 4'd5,  o1: 32'd16, o2: zx, wr: ins[20:16], we: 1'b0, ill: 1'b0};
        default:      d.ill = 1'b1;
      endcase
    end
    if (d.ill) d = '{op: 4'd0, o1: 32'd0, o2: 32'd0, wr: 5'd0, we: 1'b0, ill: 1'b1};
    else       d.we = (d.wr != 5'd0);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ent   = '0;
    m_cnt   = 16'h0000;
  endtask

  task automatic model_update();
    dec_t d;
    if (bus.flush) begin
      m_valid = 1'b0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      d       = ref_decode(bus.instr, bus.rs_data, bus.rt_data);
      m_valid = 1'b1;
      m_ent   = d;
      if (!d.ill) m_cnt = m_cnt + 16'd1;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, m_valid});
    chk({tag, ".in_ready"},  {31'b0, bus.in_ready},  {31'b0, (!m_valid || bus.out_ready)});
    chk({tag, ".alu_op"},    {28'b0, bus.alu_op},    {28'b0, m_ent.op});
    chk({tag, ".opnd1"},     bus.alu_opnd1,          m_ent.o1);
    chk({tag, ".opnd2"},     bus.alu_opnd2,          m_ent.o2);
    chk({tag, ".wr_reg"},    {27'b0, bus.wr_reg},    {27'b0, m_ent.wr});
    chk({tag, ".wr_en"},     {31'b0, bus.wr_en},     {31'b0, m_ent.we});
    chk({tag, ".illegal"},   {31'b0, bus.illegal},   {31'b0, m_ent.ill});
    chk({tag, ".issue_cnt"}, {16'b0, bus.issue_cnt}, {16'b0, m_cnt});
    $display("step %s: v=%0b op=%h o1=%h o2=%h wr=%0d we=%0b ill=%0b cnt=%h",
             tag, bus.out_valid, bus.alu_op, bus.alu_opnd1, bus.alu_opnd2,
             bus.wr_reg, bus.wr_en, bus.illegal, bus.issue_cnt);
  endtask

  task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic fl, input logic ordy);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.rs_data   = rs;
    bus.rt_data   = rt;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step_chk(input string tag);
    step();
    check_model(tag);
  endtask

  logic [5:0] rfn [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                          6'h2A, 6'h2B, 6'h0A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] iop [7]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

  initial begin
    logic [31:0] snap_o1;
    logic [31:0] snap_o2;
    logic [15:0] snap_cnt;
    logic [31:0] ins;
    int          r;

    rst_n = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // addi $9,$8,-1 on the first edge out of reset
    set_in(1'b1, 32'h2109FFFF, 32'd5, 32'd0, 1'b0, 1'b1);
    step_chk("addi");
    chk("addi.op_const",  {28'b0, bus.alu_op}, 32'd0);
    chk("addi.o2_const",  bus.alu_opnd2, 32'hFFFFFFFF);
    chk("addi.wr_const",  {27'b0, bus.wr_reg}, 32'd9);
    chk("addi.cnt_const", {16'b0, bus.issue_cnt}, 32'd1);

    set_in(1'b1, 32'h00095100, 32'h0, 32'hA, 1'b0, 1'b1);
    step_chk("sll");
    chk("sll.op_const", {28'b0, bus.alu_op}, 32'd5);
    chk("sll.o1_const", bus.alu_opnd1, 32'd4);
    chk("sll.wr_const", {27'b0, bus.wr_reg}, 32'd10);

    set_in(1'b1, 32'h3C081234, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    step_chk("lui");
    chk("lui.o1_const", bus.alu_opnd1, 32'd16);
    chk("lui.o2_const", bus.alu_opnd2, 32'h1234);

    // Backpressure: hold for five cycles while decode keeps offering a new word
    set_in(1'b1, 32'h01095020, 32'h11, 32'h22, 1'b0, 1'b0);
    step_chk("bp_load");
    snap_o1 = bus.alu_opnd1;
    snap_o2 = bus.alu_opnd2;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h01095022, 32'h33 + i, 32'h44, 1'b0, 1'b0);
      step_chk("bp_hold");
      chk("bp_hold.o1_stable", bus.alu_opnd1, snap_o1);
      chk("bp_hold.o2_stable", bus.alu_opnd2, snap_o2);
      chk("bp_hold.in_ready0", {31'b0, bus.in_ready}, 32'd0);
    end
    set_in(1'b1, 32'h01095022, 32'h77, 32'h44, 1'b0, 1'b1);
    step_chk("bp_release");
    chk("bp_release.op_sub", {28'b0, bus.alu_op}, 32'd10);
    chk("bp_release.valid",  {31'b0, bus.out_valid}, 32'd1);

    // Flush against a held entry and a same-cycle offer
    set_in(1'b1, 32'h012A5825, 32'h5, 32'h6, 1'b0, 1'b0);
    step_chk("fl_load");
    snap_cnt = bus.issue_cnt;
    set_in(1'b1, 32'h012A5826, 32'h5, 32'h6, 1'b1, 1'b0);
    step_chk("flush");
    chk("flush.valid0",  {31'b0, bus.out_valid}, 32'd0);
    chk("flush.cnt_same", {16'b0, bus.issue_cnt}, {16'b0, snap_cnt});

    set_in(1'b1, 32'h08000000, 32'h1, 32'h2, 1'b0, 1'b1);
    snap_cnt = m_cnt;
    step_chk("illegal_j");
    chk("illegal_j.ill",  {31'b0, bus.illegal}, 32'd1);
    chk("illegal_j.cnt",  {16'b0, bus.issue_cnt}, {16'b0, snap_cnt});

    set_in(1'b1, 32'h20000007, 32'h1, 32'h2, 1'b0, 1'b1);
    step_chk("addi_r0");
    chk("addi_r0.we0", {31'b0, bus.wr_en}, 32'd0);
    chk("addi_r0.cnt", {16'b0, bus.issue_cnt}, {16'b0, snap_cnt + 16'd1});

    set_in(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step_chk("drain");

    // Randomized traffic over legal templates and raw words
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      r   = $urandom_range(0, 9);
      if (r < 4) begin
        ins[31:26] = 6'h00;
        ins[5:0]   = rfn[$urandom_range(0, 16)];
      end else if (r < 8) begin
        ins[31:26] = iop[$urandom_range(0, 6)];
      end
      set_in($urandom_range(0, 3) != 0, ins, $urandom, $urandom,
             $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      step_chk("rand");
    end

    // Drive the counter to 0xFFFF, then one more legal capture wraps it
    set_in(1'b1, 32'h20000007, 32'h0, 32'h0, 1'b0, 1'b1);
    while (m_cnt != 16'hFFFF) step();
    check_model("preload");
    step_chk("wrap");
    chk("wrap.cnt0", {16'b0, bus.issue_cnt}, 32'd0);

    // Asynchronous reset in the middle of a stalled entry
    set_in(1'b1, 32'h01095020, 32'h9, 32'h8, 1'b0, 1'b0);
    step_chk("rst_load");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_async");
    chk("rst_async.in_ready1", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 32'h2109FFFF, 32'd3, 32'd0, 1'b0, 1'b1);
    step_chk("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
